uart_tx_scheduler: RTL

//  Shares the single UART transmitter between NUM_REQ byte requesters: round-robin arbitration.

---
 rtl/uart_tx_scheduler_pkg.sv | 21 ++
 rtl/uart_tx_scheduler_if.sv | 31 +++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 30 +++
 rtl/uart_tx_scheduler.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART TX scheduler: FSM states, parity codes,
// tick counter width and grant index width.
package uart_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        START = 3'd2,
        BUSY  = 3'd3,
        GAP   = 3'd4
    } state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    localparam int TICK_CNT_W = 9;
    localparam int GRANT_W    = 3;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester/transmitter bundle of the UART TX scheduler; slave = scheduler side,
// master = requesters plus transmitter side.
interface uart_tx_scheduler_if
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [2*NUM_REQ-1:0] req_parity;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 b_tick;
    logic                 tx_done;
    logic                 tx_start_n;
    logic [7:0]           tx_data;
    logic [1:0]           tx_parity;
    logic                 busy;
    logic [GRANT_W-1:0]   grant_id;
    logic                 timeout_err;

    modport slave (
        input  req_valid, req_data, req_parity, b_tick, tx_done,
        output req_ready, tx_start_n, tx_data, tx_parity, busy, grant_id, timeout_err
    );

    modport master (
        output req_valid, req_data, req_parity, b_tick, tx_done,
        input  req_ready, tx_start_n, tx_data, tx_parity, busy, grant_id, timeout_err
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid requester after the pointer, wrapping.
module uart_rr_arbiter
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
)(
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [GRANT_W-1:0] ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [GRANT_W-1:0] idx_o,
    output logic               any_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        // Offsets 1..NUM_REQ visit every index once, the pointer itself last.
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any_o && valid_i[i] && (i == (int'(ptr_i) + off) % NUM_REQ)) begin
                    grant_o[i] = 1'b1;
                    idx_o      = GRANT_W'(i);
                    any_o      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte requesters (round robin) and sequences
// each frame. Optional watchdog enabled by defining TX_TIMEOUT_EN.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int GAP_TICKS     = 16,
    parameter int TIMEOUT_TICKS = 256
)(
    input logic               clk,
    input logic               reset,
    uart_tx_scheduler_if.slave bus
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_TICKS < 0 || GAP_TICKS > 511 ||
        TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 511) begin : g_bad_params
        $error("uart_tx_scheduler: parameter out of range");
    end

    localparam logic [TICK_CNT_W-1:0] GAP_CNT = TICK_CNT_W'(GAP_TICKS);
    localparam state_e GAP_NEXT = (GAP_TICKS == 0) ? IDLE : GAP;

    state_e                 state_q;
    logic [NUM_REQ-1:0]     ready_q;
    logic                   txStartN_q;
    logic [7:0]             txData_q;
    logic [1:0]             txParity_q;
    logic                   busy_q;
    logic [GRANT_W-1:0]     ptr_q;
    logic [TICK_CNT_W-1:0]  tickCnt_q;
    logic [TICK_CNT_W-1:0]  tickCnt_d;
    logic                   txDone_q;
    logic                   doneRise;
    logic                   wdExpire;

    logic [NUM_REQ-1:0]     winOneHot;
    logic [GRANT_W-1:0]     winIdx;
    logic                   winAny;
    logic [7:0]             winData;
    logic [1:0]             winParity;

    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arbiter (
        .valid_i (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (winOneHot),
        .idx_o   (winIdx),
        .any_o   (winAny)
    );

    always_comb begin
        winData   = '0;
        winParity = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winOneHot[i]) begin
                winData   = bus.req_data[8*i +: 8];
                winParity = bus.req_parity[2*i +: 2];
            end
        end
    end

    assign tickCnt_d = (tickCnt_q == '1) ? tickCnt_q : tickCnt_q + 1'b1;
    assign doneRise  = bus.tx_done & ~txDone_q;

`ifdef TX_TIMEOUT_EN
    localparam logic [TICK_CNT_W-1:0] TIMEOUT_CNT = TICK_CNT_W'(TIMEOUT_TICKS);
    logic timeoutErr_q;
    assign wdExpire        = bus.b_tick && (tickCnt_d >= TIMEOUT_CNT);
    assign bus.timeout_err = timeoutErr_q;
`else
    assign wdExpire        = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // The tick counter is the watchdog in START/BUSY and the gap timer in GAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ready_q    <= '0;
            txStartN_q <= 1'b1;
            txData_q   <= '0;
            txParity_q <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= GRANT_W'(NUM_REQ - 1);
            tickCnt_q  <= '0;
            txDone_q   <= 1'b0;
`ifdef TX_TIMEOUT_EN
            timeoutErr_q <= 1'b0;
`endif
        end else begin
            ready_q  <= '0;
            txDone_q <= bus.tx_done;
            case (state_q)
                IDLE: begin
                    if (|bus.req_valid) begin
                        state_q <= ARB;
                        busy_q  <= 1'b1;
                    end
                end
                ARB: begin
                    if (winAny) begin
                        ready_q    <= winOneHot;
                        txData_q   <= winData;
                        txParity_q <= winParity;
                        ptr_q      <= winIdx;
                        txStartN_q <= 1'b0;
                        tickCnt_q  <= '0;
                        state_q    <= START;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                START, BUSY: begin
                    if ((state_q == BUSY && doneRise) || wdExpire) begin
`ifdef TX_TIMEOUT_EN
                        if (wdExpire && !(state_q == BUSY && doneRise)) timeoutErr_q <= 1'b1;
`endif
                        txStartN_q <= 1'b1;
                        tickCnt_q  <= '0;
                        state_q    <= GAP_NEXT;
                        busy_q     <= (GAP_NEXT != IDLE);
                    end else if (bus.b_tick) begin
                        tickCnt_q <= tickCnt_d;
                        if (state_q == START) begin
                            txStartN_q <= 1'b1;
                            state_q    <= BUSY;
                        end
                    end
                end
                GAP: begin
                    if (bus.b_tick) begin
                        if (tickCnt_d >= GAP_CNT) begin
                            tickCnt_q <= '0;
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                        end else begin
                            tickCnt_q <= tickCnt_d;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.tx_start_n = txStartN_q;
    assign bus.tx_data    = txData_q;
    assign bus.tx_parity  = txParity_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = ptr_q;

endmodule
